// File: rtl/n64_pkg.sv
// Shared joybus definitions: command codes, expected frame lengths and the
// receiver FSM state type.
package n64_pkg;

  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_WRITE = 8'h03;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  localparam logic [5:0] MAX_BYTE_IDX = 6'd34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_STOP_LOW,
    ST_ERR
  } rx_state_e;

  // Number of console bytes (command byte included) preceding the stop bit.
  function automatic logic [5:0] cmd_len(input logic [7:0] c);
    case (c)
      CMD_READ:                        return 6'd3;
      CMD_WRITE:                       return 6'd35;
      CMD_INFO, CMD_POLL, CMD_RESET:   return 6'd1;
      default:                         return 6'd1;
    endcase
  endfunction

endpackage

// File: rtl/n64_pulse_meas.sv
// Line conditioner: 2-flop synchronizer, registered edge events and a
// saturating counter giving the length of the current line level.
module n64_pulse_meas #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  output logic             rise,
  output logic             fall,
  output logic             level,
  output logic [CNT_W-1:0] count
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Count reloads to 1 on the edge event so that, when the next edge event
  // is seen, count equals the width of the level just ended in clocks.
  always_comb begin
    sync1_d = data_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
    fall_d  = ~sync2_q & prev_q;
    count_d = count_q;
    if (rise_q || fall_q) begin
      count_d = CNT_W'(1);
    end else if (count_q != '1) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign rise  = rise_q;
  assign fall  = fall_q;
  assign level = prev_q;
  assign count = count_q;

endmodule

// File: rtl/n64_cmd_rx.sv
// Console-side joybus receiver: decodes pulse-width bits into bytes, tracks
// the command-implied frame length and validates the stop bit.
module n64_cmd_rx
  import n64_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = 50,
  parameter int unsigned MIN_LOW_US4 = 1,
  parameter int unsigned MAX_LOW_US  = 5,
  parameter int unsigned MAX_HIGH_US = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic [7:0] cmd,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy,
  output logic [5:0] byte_idx
);

  localparam int unsigned THRESH   = 2 * CLKS_PER_US;
  localparam int unsigned MIN_LOW  = CLKS_PER_US * MIN_LOW_US4 / 4;
  localparam int unsigned MAX_LOW  = MAX_LOW_US * CLKS_PER_US;
  localparam int unsigned MAX_HIGH = MAX_HIGH_US * CLKS_PER_US;
  localparam int unsigned CNT_LIM  = (MAX_LOW > MAX_HIGH) ? MAX_LOW : MAX_HIGH;
  localparam int unsigned CNT_W    = $clog2(CNT_LIM + 2);

  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] MIN_LOW_C  = CNT_W'(MIN_LOW);
  localparam logic [CNT_W-1:0] MAX_LOW_C  = CNT_W'(MAX_LOW);
  localparam logic [CNT_W-1:0] MAX_HIGH_C = CNT_W'(MAX_HIGH);

  logic             rise, fall, level;
  logic [CNT_W-1:0] count;

  n64_pulse_meas #(.CNT_W(CNT_W)) u_meas (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .rise    (rise),
    .fall    (fall),
    .level   (level),
    .count   (count)
  );

  rx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [5:0] byte_idx_q, byte_idx_d;
  logic [5:0] exp_len_q, exp_len_d;
  logic       stop_pending_q, stop_pending_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_byte_valid_q, rx_byte_valid_d;
  logic [7:0] cmd_q, cmd_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q, busy_d;

  logic       bit_val;
  logic [7:0] shifted;
  logic [5:0] len_now;
  logic       go_err;

  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    byte_idx_d      = byte_idx_q;
    exp_len_d       = exp_len_q;
    stop_pending_d  = stop_pending_q;
    byte_done_d     = byte_done_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    cmd_d           = cmd_q;
    frame_done_d    = 1'b0;
    frame_err_d     = 1'b0;
    busy_d          = busy_q;
    go_err          = 1'b0;

    bit_val = (count < THRESH_C);
    shifted = {shift_q[6:0], bit_val};
    len_now = (byte_idx_q == 6'd0) ? cmd_len(shifted) : exp_len_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d        = ST_LOW;
          busy_d         = 1'b1;
          bit_cnt_d      = '0;
          byte_idx_d     = '0;
          stop_pending_d = 1'b0;
          byte_done_d    = 1'b0;
        end
      end
      ST_LOW: begin
        if (count >= MAX_LOW_C) begin
          go_err = 1'b1;
        end else if (rise) begin
          if (count < MIN_LOW_C) begin
            go_err = 1'b1;
          end else begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = ST_HIGH;
            if (bit_cnt_q == 3'd7) begin
              rx_byte_d       = shifted;
              rx_byte_valid_d = 1'b1;
              byte_done_d     = 1'b1;
              if (byte_idx_q == 6'd0) begin
                cmd_d     = shifted;
                exp_len_d = len_now;
              end
              if (byte_idx_q + 6'd1 >= len_now) begin
                stop_pending_d = 1'b1;
              end
            end
          end
        end
      end
      ST_HIGH: begin
        // byte_idx advances at the start of the next byte, so it still names
        // the completed byte while rx_byte_valid is high.
        if (fall) begin
          if (stop_pending_q) begin
            state_d = ST_STOP_LOW;
          end else begin
            state_d = ST_LOW;
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              if (byte_idx_q != MAX_BYTE_IDX) begin
                byte_idx_d = byte_idx_q + 6'd1;
              end
            end
          end
        end else if (count >= MAX_HIGH_C) begin
          go_err = 1'b1;
        end
      end
      ST_STOP_LOW: begin
        if (count >= MAX_LOW_C) begin
          go_err = 1'b1;
        end else if (rise) begin
          if (count >= MIN_LOW_C && count < THRESH_C) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      ST_ERR: begin
        if (level && count >= MAX_HIGH_C) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_err) begin
      state_d     = ST_ERR;
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      byte_idx_q      <= '0;
      exp_len_q       <= 6'd1;
      stop_pending_q  <= 1'b0;
      byte_done_q     <= 1'b0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      cmd_q           <= '0;
      frame_done_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_idx_q      <= byte_idx_d;
      exp_len_q       <= exp_len_d;
      stop_pending_q  <= stop_pending_d;
      byte_done_q     <= byte_done_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      cmd_q           <= cmd_d;
      frame_done_q    <= frame_done_d;
      frame_err_q     <= frame_err_d;
      busy_q          <= busy_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign cmd           = cmd_q;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;
  assign busy          = busy_q;
  assign byte_idx      = byte_idx_q;

endmodule

// File: tb/tb_n64_cmd_rx.sv
// Directed bench for n64_cmd_rx at default parameters (50 clk per us).
module tb_n64_cmd_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic [7:0] cmd;
  logic       frame_done;
  logic       frame_err;
  logic       busy;
  logic [5:0] byte_idx;

  n64_cmd_rx #(
    .CLKS_PER_US (50),
    .MIN_LOW_US4 (1),
    .MAX_LOW_US  (5),
    .MAX_HIGH_US (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .cmd           (cmd),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .busy          (busy),
    .byte_idx      (byte_idx)
  );

  always #10 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor; totals only grow, the stimulus side keeps base snapshots.
  logic [7:0]  mon_bytes [0:255];
  logic [5:0]  mon_idx   [0:255];
  int unsigned nvalid = 0, ndone = 0, nerr = 0, n_overlap = 0;
  int unsigned done_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_byte_valid) begin
        mon_bytes[nvalid[7:0]] <= rx_byte;
        mon_idx[nvalid[7:0]]   <= byte_idx;
        nvalid <= nvalid + 1;
      end
      if (frame_done) begin
        ndone    <= ndone + 1;
        done_cyc <= cyc;
      end
      if (frame_err) nerr <= nerr + 1;
      if (frame_done && rx_byte_valid) n_overlap <= n_overlap + 1;
    end
  end

  int unsigned b_valid, b_done, b_err, rise_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    b_valid = nvalid;
    b_done  = ndone;
    b_err   = nerr;
  endtask

  task automatic line(input logic v, input int unsigned n);
    data_in = v;
    if (v) rise_cyc = cyc;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int unsigned lo, input int unsigned hi);
    line(1'b0, lo);
    line(1'b1, hi);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(50, 150);
    else   pulse(150, 50);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_stop();
    pulse(50, 100);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_byte"},  {24'd0, rx_byte}, 32'h0);
    check({tag, "_cmd"},      {24'd0, cmd}, 32'h0);
    check({tag, "_busy"},     {31'd0, busy}, 32'h0);
    check({tag, "_byte_idx"}, {26'd0, byte_idx}, 32'h0);
    check({tag, "_strobes"},  {29'd0, rx_byte_valid, frame_done, frame_err}, 32'h0);
  endtask

  initial begin
    // Reset
    repeat (5) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    line(1'b1, 20);

    // POLL 0x01
    mark();
    send_byte(8'h01);
    send_stop();
    check("poll_nvalid", nvalid - b_valid, 1);
    check("poll_byte",   {24'd0, mon_bytes[b_valid[7:0]]}, 32'h01);
    check("poll_idx",    {26'd0, mon_idx[b_valid[7:0]]}, 32'h0);
    check("poll_cmd",    {24'd0, cmd}, 32'h01);
    check("poll_done",   ndone - b_done, 1);
    check("poll_err",    nerr - b_err, 0);
    check("poll_latency", done_cyc - rise_cyc, 4);
    check("poll_busy",   {31'd0, busy}, 32'h0);
    line(1'b1, 20);

    // READ 0x02 + address 0x8001
    mark();
    send_byte(8'h02);
    send_byte(8'h80);
    send_byte(8'h01);
    send_stop();
    check("read_nvalid", nvalid - b_valid, 3);
    check("read_b0", {24'd0, mon_bytes[b_valid[7:0]]}, 32'h02);
    check("read_b1", {24'd0, mon_bytes[b_valid[7:0] + 8'd1]}, 32'h80);
    check("read_b2", {24'd0, mon_bytes[b_valid[7:0] + 8'd2]}, 32'h01);
    check("read_i0", {26'd0, mon_idx[b_valid[7:0]]}, 32'd0);
    check("read_i1", {26'd0, mon_idx[b_valid[7:0] + 8'd1]}, 32'd1);
    check("read_i2", {26'd0, mon_idx[b_valid[7:0] + 8'd2]}, 32'd2);
    check("read_done", ndone - b_done, 1);
    check("read_err",  nerr - b_err, 0);
    check("read_cmd",  {24'd0, cmd}, 32'h02);
    line(1'b1, 20);

    // Threshold: 99 clk low -> 1, 100 clk low -> 0
    mark();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    pulse(99, 101);
    pulse(100, 100);
    send_stop();
    check("thr_a_byte", {24'd0, mon_bytes[b_valid[7:0]]}, 32'hFE);
    check("thr_a_done", ndone - b_done, 1);
    line(1'b1, 20);
    mark();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    pulse(100, 100);
    pulse(99, 101);
    send_stop();
    check("thr_b_byte", {24'd0, mon_bytes[b_valid[7:0]]}, 32'hFD);
    check("thr_b_done", ndone - b_done, 1);
    line(1'b1, 20);

    // Glitch mid-byte
    mark();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    line(1'b0, 10);
    line(1'b1, 240);
    check("glitch_err",    nerr - b_err, 1);
    check("glitch_nvalid", nvalid - b_valid, 0);
    check("glitch_busy_hold", {31'd0, busy}, 32'h1);
    line(1'b1, 20);
    check("glitch_busy_drop", {31'd0, busy}, 32'h0);
    check("glitch_done",   ndone - b_done, 0);
    mark();
    send_byte(8'h00);
    send_stop();
    check("after_glitch_byte", {24'd0, mon_bytes[b_valid[7:0]]}, 32'h00);
    check("after_glitch_cmd",  {24'd0, cmd}, 32'h00);
    check("after_glitch_done", ndone - b_done, 1);
    check("after_glitch_err",  nerr - b_err, 0);
    line(1'b1, 20);

    // 0xFF followed by a stop as long as a 0 bit
    mark();
    send_byte(8'hFF);
    pulse(150, 300);
    check("longstop_err",    nerr - b_err, 1);
    check("longstop_done",   ndone - b_done, 0);
    check("longstop_cmd",    {24'd0, cmd}, 32'hFF);
    check("longstop_nvalid", nvalid - b_valid, 1);
    check("longstop_busy",   {31'd0, busy}, 32'h0);

    // Reset during bit 4
    mark();
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    line(1'b0, 20);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    data_in = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    line(1'b1, 20);
    check("midrst_nostrobe", (nvalid - b_valid) + (ndone - b_done) + (nerr - b_err), 0);
    mark();
    send_byte(8'h01);
    send_stop();
    check("post_rst_byte", {24'd0, mon_bytes[b_valid[7:0]]}, 32'h01);
    check("post_rst_cmd",  {24'd0, cmd}, 32'h01);
    check("post_rst_done", ndone - b_done, 1);
    check("post_rst_err",  nerr - b_err, 0);

    check("done_valid_overlap", n_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
